reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
- Parametrised, scoreboarded successor to the Beta pipeline register file.
- Provides two combinational read ports with full ex/mem/wb bypassing.
- Adds a second write port for long-latency (multi-cycle) results, tracked by a per-register pending-count scoreboard.
- Generates the decode-stage stall for load-use and long-latency hazards.
- Sits between decode and execute; a load in wb is forwarded instead of stalling.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W.
- ZERO_REG, 31, hardwired-zero register index.
- CNT_W, 2, width of each per-register pending counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- dec_valid  in  1  decode slot holds a real instruction
- dec_ra  in  ADDR_W  source A address
- dec_rb  in  ADDR_W  source B address
- dec_rb_used  in  1  instruction reads Rb (OP class)
- dec_rc  in  ADDR_W  destination of the decode instruction
- ll_issue  in  1  decode instruction is long-latency and writes dec_rc
- ex_valid, mem_valid, wb_valid  in  1 each  stage holds a register-writing instruction
- ex_rc, mem_rc, wb_rc  in  ADDR_W each  stage destination
- ex_ld, mem_ld  in  1 each  stage instruction is LD/LDR (data not yet available)
- ex_data, mem_data, wb_data  in  DATA_W each  stage result (wb_data includes load data)
- ll_done  in  1  long-latency result completes this cycle
- ll_rc  in  ADDR_W  long-latency destination
- ll_data  in  DATA_W  long-latency result
- rd1, rd2  out  DATA_W  read data A/B
- stall  out  1  hold decode and earlier stages this cycle
- sb_err  out  1  sticky scoreboard underflow/overflow flag

Behaviour:
- Reset (async, rst=1): all array entries are 0, all pending counters are 0, sb_err=0. While rst is high, stall=0 and rd1/rd2 follow the bypass rules with an all-zero array.
- Writes (posedge clk):
  - wb_valid writes wb_data to wb_rc.
  - ll_done writes ll_data to ll_rc.
  - Same address in the same cycle: the ll port wins.
  - Writes to ZERO_REG are dropped.
- Read priority, per port (combinational, zero latency):
  1. Address is ZERO_REG -> 0.
  2. ex_valid && ex_rc match && !ex_ld -> ex_data.
  3. mem_valid && mem_rc match && !mem_ld -> mem_data.
  4. wb_valid && wb_rc match -> wb_data. Loads are forwarded here.
  5. ll_done && ll_rc match -> ll_data.
  6. Otherwise -> array contents.
  - Port B applies steps 2-5 only when dec_rb_used=1; otherwise it reads the array directly.
- Stall (only when dec_valid=1). Asserted if any of the following holds for Ra, or for Rb when dec_rb_used=1; ZERO_REG never stalls:
  - ex_valid && ex_ld && ex_rc matches.
  - mem_valid && mem_ld && mem_rc matches.
  - pending[src] != 0, unless pending[src]==1 && ll_done && ll_rc==src; in that case ll_data is forwarded and there is no stall.
  - ll_issue && pending[dec_rc] is saturated (all ones).
- Scoreboard counters, per register, updated at posedge:
  - Increment when dec_valid && ll_issue && !stall && dec_rc != ZERO_REG.
  - Decrement when ll_done && ll_rc != ZERO_REG.
  - Increment and decrement of the same register in one cycle: the count is unchanged.
  - Decrement at 0: counter stays 0 and sb_err is set.
  - Increment at saturation cannot occur because of the stall; if it is forced, the counter holds and sb_err is set.
  - sb_err clears only on rst.
- Invalid stage slots (valid=0) never forward and never stall, regardless of rc or ld.
- Reset asserted mid-operation clears all pending counts immediately. In-flight ll_done pulses after reset release then set sb_err by underflow, which is the intended detection.

Test Plan:
1. After reset, read r3 and r31 -> rd1=0, rd2=0, stall=0, sb_err=0.
2. Bypass priority:
   - Setup: r5=0x11 in the array, wb writes r5=0x22, mem r5=0x33, ex r5=0x44 (none loads); dec_ra=dec_rb=5, dec_rb_used=1.
   - Required: rd1=rd2=0x44.
   - Drop ex_valid -> 0x33; drop mem_valid -> 0x22.
   - Set dec_rb_used=0 -> rd2=0x11.
3. Load-use:
   - ex_ld with ex_rc=7, dec_ra=7 -> stall=1.
   - Next cycle mem_ld with mem_rc=7 -> stall=1.
   - Next cycle wb_rc=7, wb_data=0xABCD -> stall=0, rd1=0xABCD.
4. Long-latency:
   - Issue ll_issue to r9 twice -> pending[9]=2; a reader of r9 stalls.
   - First ll_done(9, 0x1) -> still stalls.
   - Second ll_done(9, 0x2) -> same-cycle forward, rd1=0x2, stall=0; array r9=0x2 next cycle.
5. Saturation and error:
   - Issue three ll_issue to r4 (CNT_W=2) -> pending[4]=3.
   - A fourth ll_issue to r4 -> stall=1, count stays 3.
   - ll_done to r6 with pending 0 -> sb_err=1, held until rst.
6. Conflicts:
   - wb and ll write r2 in the same cycle (0xAA, 0xBB) -> r2=0xBB.
   - Write to r31 -> r31 still reads 0.
   - Assert rst with pending[9]=1 -> counter 0, stall=0 immediately.

Source files
------------

// File: rtl/reg_file_sb.sv
// -----------------------------------------------------------------------------
// reg_file_sb
//
// This is the Beta pipeline register file, with a pending-count scoreboard.
// It sits between decode and execute and has these features:
//   - Two combinational read ports (A, B). Each port forwards results from
//     ex, mem and wb, and also forwards a long-latency result that completes
//     in the same cycle.
//   - Two write ports: the normal wb port, and a long-latency (ll) port.
//     When both ports target the same register in one cycle, the ll port wins.
//   - One saturating pending counter per register. It counts the
//     long-latency results that are still outstanding for that register.
//   - A decode stall for two cases: load-use hazards in ex or mem, and reads
//     of registers that still have long-latency results outstanding.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   dec_valid                    decode slot holds a real instruction
//   dec_ra, dec_rb, dec_rb_used  source addresses; Rb is only read when used
//   dec_rc, ll_issue             destination; instruction is long-latency
//   {ex,mem,wb}_valid/_rc/_data  in-flight register-writing instructions
//   ex_ld, mem_ld                stage result is a load (data not yet known)
//   ll_done, ll_rc, ll_data      long-latency completion / write port
//   rd1, rd2                     read data for source A / B
//   stall                        hold decode and earlier stages
//   sb_err                       sticky scoreboard underflow/overflow flag
// -----------------------------------------------------------------------------
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31,
  parameter int CNT_W    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dec_valid,
  input  logic [ADDR_W-1:0] dec_ra,
  input  logic [ADDR_W-1:0] dec_rb,
  input  logic              dec_rb_used,
  input  logic [ADDR_W-1:0] dec_rc,
  input  logic              ll_issue,
  input  logic              ex_valid,
  input  logic              mem_valid,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] ex_rc,
  input  logic [ADDR_W-1:0] mem_rc,
  input  logic [ADDR_W-1:0] wb_rc,
  input  logic              ex_ld,
  input  logic              mem_ld,
  input  logic [DATA_W-1:0] ex_data,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ll_done,
  input  logic [ADDR_W-1:0] ll_rc,
  input  logic [DATA_W-1:0] ll_data,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              stall,
  output logic              sb_err
);

  localparam int                NUM_REGS  = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [CNT_W-1:0]  pend_q [NUM_REGS];
  logic [CNT_W-1:0]  pend_d [NUM_REGS];
  logic              sb_err_q;
  logic              sb_err_d;

  // ---------------------------------------------------------------------------
  // Forwarding network.
  // The youngest producer wins. A load in ex or mem has no data yet, so it
  // is skipped here; the stall logic covers that case. A load in wb already
  // carries its data in wb_data, so wb forwards loads too.
  // ---------------------------------------------------------------------------
  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] addr,
    input logic              use_bypass,
    input logic [DATA_W-1:0] arr_val
  );
    logic [DATA_W-1:0] val;
    val = arr_val;
    if (addr == ZERO_ADDR) begin
      val = '0;
    end else if (use_bypass) begin
      if (ex_valid && ex_rc == addr && !ex_ld) begin
        val = ex_data;
      end else if (mem_valid && mem_rc == addr && !mem_ld) begin
        val = mem_data;
      end else if (wb_valid && wb_rc == addr) begin
        val = wb_data;
      end else if (ll_done && ll_rc == addr) begin
        val = ll_data;
      end
    end
    return val;
  endfunction

  always_comb begin
    rd1 = read_port(dec_ra, 1'b1, regs_q[dec_ra]);
    // When the instruction does not use Rb, port B reads the array directly.
    // The Rb field is then an immediate or don't-care, so a bypass match
    // on it would have no meaning.
    rd2 = read_port(dec_rb, dec_rb_used, regs_q[dec_rb]);
  end

  // ---------------------------------------------------------------------------
  // Hazard detection for one source register.
  // A register with exactly one outstanding long-latency result does not
  // stall if that result completes this cycle. In that case read_port
  // forwards ll_data instead.
  // ---------------------------------------------------------------------------
  function automatic logic src_hazard(
    input logic [ADDR_W-1:0] src,
    input logic [CNT_W-1:0]  pend
  );
    logic load_use;
    logic ll_busy;
    load_use = (ex_valid  && ex_ld  && ex_rc  == src) ||
               (mem_valid && mem_ld && mem_rc == src);
    ll_busy  = (pend != '0) &&
               !(pend == CNT_ONE && ll_done && ll_rc == src);
    return (src != ZERO_ADDR) && (load_use || ll_busy);
  endfunction

  logic haz_a;
  logic haz_b;
  logic haz_sat;

  always_comb begin
    haz_a   = src_hazard(dec_ra, pend_q[dec_ra]);
    haz_b   = dec_rb_used && src_hazard(dec_rb, pend_q[dec_rb]);
    // If the destination counter is already full, a new long-latency issue
    // must wait. Otherwise the counter would wrap and lose track of a result.
    haz_sat = ll_issue && (pend_q[dec_rc] == CNT_MAX);
    stall   = !rst && dec_valid && (haz_a || haz_b || haz_sat);
  end

  // ---------------------------------------------------------------------------
  // Register array write ports.
  // The ll port is applied last, so it overrides wb on an address collision.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written here first receives a full default
    // (hold the current value). No path leaves it unassigned, so no latch
    // is inferred.
    regs_d = regs_q;
    if (wb_valid && wb_rc != ZERO_ADDR) begin
      regs_d[wb_rc] = wb_data;
    end
    if (ll_done && ll_rc != ZERO_ADDR) begin
      regs_d[ll_rc] = ll_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard counters.
  // An issue and a completion on the same register in the same cycle cancel
  // out. A completion with nothing outstanding, or an issue into a full
  // counter, leaves the counter unchanged and raises the sticky error.
  // ---------------------------------------------------------------------------
  logic inc_any;
  logic dec_any;

  always_comb begin
    inc_any  = dec_valid && ll_issue && !stall && (dec_rc != ZERO_ADDR);
    dec_any  = ll_done && (ll_rc != ZERO_ADDR);
    pend_d   = pend_q;
    sb_err_d = sb_err_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      logic inc_i;
      logic dec_i;
      inc_i = inc_any && (dec_rc == ADDR_W'(i));
      dec_i = dec_any && (ll_rc == ADDR_W'(i));
      unique case ({inc_i, dec_i})
        2'b10: begin
          if (pend_q[i] == CNT_MAX) begin
            sb_err_d = 1'b1;
          end else begin
            pend_d[i] = pend_q[i] + CNT_ONE;
          end
        end
        2'b01: begin
          if (pend_q[i] == '0) begin
            sb_err_d = 1'b1;
          end else begin
            pend_d[i] = pend_q[i] - CNT_ONE;
          end
        end
        default: pend_d[i] = pend_q[i];
      endcase
    end
  end

  assign sb_err = sb_err_q;

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the array must read as all-zero straight out of reset, so it is
      // built from resettable flops. It cannot map onto an unreset RAM macro.
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
        pend_q[i] <= '0;
      end
      sb_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the values
      // from before the edge. This keeps the update order-independent
      // between processes.
      regs_q   <= regs_d;
      pend_q   <= pend_d;
      sb_err_q <= sb_err_d;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// -----------------------------------------------------------------------------
// tb_reg_file_sb
//
// This is a scoreboard bench for reg_file_sb.
// - The driver applies one input vector per cycle, shortly after posedge.
// - It predicts rd1/rd2/stall/sb_err from a behavioural model kept here:
//   a plain register array plus integer outstanding-result counts.
// - It pushes each prediction into a queue.
// - The monitor pops the queue and compares on every negedge.
// - After the directed scenarios comes a randomized phase.
// -----------------------------------------------------------------------------
module tb_reg_file_sb;

  localparam int ZR   = 31;
  localparam int CMAX = 3;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, dec_valid, dec_rb_used, ll_issue;
  logic [4:0]  dec_ra, dec_rb, dec_rc;
  logic        ex_valid, mem_valid, wb_valid, ex_ld, mem_ld, ll_done;
  logic [4:0]  ex_rc, mem_rc, wb_rc, ll_rc;
  logic [31:0] ex_data, mem_data, wb_data, ll_data;
  logic [31:0] rd1, rd2;
  logic        stall, sb_err;

  reg_file_sb dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_ra(dec_ra), .dec_rb(dec_rb),
    .dec_rb_used(dec_rb_used), .dec_rc(dec_rc), .ll_issue(ll_issue),
    .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
    .ex_rc(ex_rc), .mem_rc(mem_rc), .wb_rc(wb_rc),
    .ex_ld(ex_ld), .mem_ld(mem_ld),
    .ex_data(ex_data), .mem_data(mem_data), .wb_data(wb_data),
    .ll_done(ll_done), .ll_rc(ll_rc), .ll_data(ll_data),
    .rd1(rd1), .rd2(rd2), .stall(stall), .sb_err(sb_err)
  );

  typedef struct packed {
    logic        rst, dec_valid, dec_rb_used, ll_issue;
    logic [4:0]  dec_ra, dec_rb, dec_rc;
    logic        ex_valid, mem_valid, wb_valid, ex_ld, mem_ld, ll_done;
    logic [4:0]  ex_rc, mem_rc, wb_rc, ll_rc;
    logic [31:0] ex_data, mem_data, wb_data, ll_data;
  } stim_t;

  typedef struct packed {
    logic [31:0] rd1, rd2;
    logic        stall, sb_err;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  // Behavioural reference model
  logic [31:0] m_regs [32];
  int          m_pend [32];
  bit          m_err;
  stim_t       cur;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic void m_clear();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 0;
    end
    m_err = 1'b0;
  endfunction

  function automatic logic [31:0] m_read(input int a, input bit byp);
    if (a == ZR) return 32'h0;
    if (byp) begin
      if (cur.ex_valid && cur.ex_rc == a && !cur.ex_ld) return cur.ex_data;
      if (cur.mem_valid && cur.mem_rc == a && !cur.mem_ld) return cur.mem_data;
      if (cur.wb_valid && cur.wb_rc == a) return cur.wb_data;
      if (cur.ll_done && cur.ll_rc == a) return cur.ll_data;
    end
    return m_regs[a];
  endfunction

  function automatic bit m_blocked(input int a);
    if (a == ZR) return 1'b0;
    if (cur.ex_valid && cur.ex_ld && cur.ex_rc == a) return 1'b1;
    if (cur.mem_valid && cur.mem_ld && cur.mem_rc == a) return 1'b1;
    if (m_pend[a] == 1 && cur.ll_done && cur.ll_rc == a) return 1'b0;
    return m_pend[a] > 0;
  endfunction

  function automatic bit m_stall();
    if (cur.rst || !cur.dec_valid) return 1'b0;
    return m_blocked(cur.dec_ra) || (cur.dec_rb_used && m_blocked(cur.dec_rb)) ||
           (cur.ll_issue && m_pend[cur.dec_rc] == CMAX);
  endfunction

  // Apply the effect of the clock edge that ends the cycle described by cur.
  function automatic void m_commit();
    bit st;
    int inc_r, dec_r;
    if (cur.rst) begin
      m_clear();
      return;
    end
    st    = m_stall();
    inc_r = (cur.dec_valid && cur.ll_issue && !st && cur.dec_rc != ZR) ? int'(cur.dec_rc) : -1;
    dec_r = (cur.ll_done && cur.ll_rc != ZR) ? int'(cur.ll_rc) : -1;
    if (cur.wb_valid && cur.wb_rc != ZR) m_regs[cur.wb_rc] = cur.wb_data;
    if (cur.ll_done && cur.ll_rc != ZR) m_regs[cur.ll_rc] = cur.ll_data;
    if (inc_r != dec_r) begin
      if (inc_r >= 0) begin
        if (m_pend[inc_r] == CMAX) m_err = 1'b1;
        else m_pend[inc_r]++;
      end
      if (dec_r >= 0) begin
        if (m_pend[dec_r] == 0) m_err = 1'b1;
        else m_pend[dec_r]--;
      end
    end
  endfunction

  task automatic apply(input stim_t s);
    rst = s.rst; dec_valid = s.dec_valid; dec_rb_used = s.dec_rb_used;
    ll_issue = s.ll_issue; dec_ra = s.dec_ra; dec_rb = s.dec_rb; dec_rc = s.dec_rc;
    ex_valid = s.ex_valid; mem_valid = s.mem_valid; wb_valid = s.wb_valid;
    ex_ld = s.ex_ld; mem_ld = s.mem_ld; ll_done = s.ll_done;
    ex_rc = s.ex_rc; mem_rc = s.mem_rc; wb_rc = s.wb_rc; ll_rc = s.ll_rc;
    ex_data = s.ex_data; mem_data = s.mem_data; wb_data = s.wb_data; ll_data = s.ll_data;
  endtask

  // One cycle: commit the previous cycle into the model, drive the new vector,
  // then queue the predicted response.
  task automatic drive(input stim_t s, input string nm);
    exp_t e;
    @(posedge clk);
    m_commit();
    #1;
    cur = s;
    apply(s);
    if (s.rst) m_clear();
    e.rd1    = m_read(int'(s.dec_ra), 1'b1);
    e.rd2    = m_read(int'(s.dec_rb), s.dec_rb_used);
    e.stall  = m_stall();
    e.sb_err = m_err;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: the outputs are combinational, so a response is due every cycle
  // in which a prediction was queued.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      check({nm, ".rd1"},    rd1,           e.rd1);
      check({nm, ".rd2"},    rd2,           e.rd2);
      check({nm, ".stall"},  {31'h0, stall},  {31'h0, e.stall});
      check({nm, ".sb_err"}, {31'h0, sb_err}, {31'h0, e.sb_err});
    end
  end

  function automatic logic [4:0] rand_addr();
    case ($urandom_range(0, 5))
      0:       return 5'd2;
      1:       return 5'd4;
      2:       return 5'd9;
      3:       return 5'd31;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  initial begin
    stim_t s;
    s = '0;
    s.rst = 1'b1;
    cur = s;
    apply(s);
    m_clear();

    // 1. reset
    drive(s, "reset_hold");
    s = '0; s.dec_valid = 1; s.dec_ra = 3; s.dec_rb = 31; s.dec_rb_used = 1;
    drive(s, "after_reset");

    // 2. bypass priority
    s = '0; s.wb_valid = 1; s.wb_rc = 5; s.wb_data = 32'h11;
    drive(s, "seed_r5");
    s = '0; s.dec_valid = 1; s.dec_ra = 5; s.dec_rb = 5; s.dec_rb_used = 0;
    s.wb_valid = 1; s.wb_rc = 5; s.wb_data = 32'h22;
    s.mem_valid = 1; s.mem_rc = 5; s.mem_data = 32'h33;
    s.ex_valid = 1; s.ex_rc = 5; s.ex_data = 32'h44;
    drive(s, "byp_rb_unused");
    s.dec_rb_used = 1;
    drive(s, "byp_ex");
    s.ex_valid = 0;
    drive(s, "byp_mem");
    s.mem_valid = 0;
    drive(s, "byp_wb");

    // 3. load-use
    s = '0; s.dec_valid = 1; s.dec_ra = 7; s.ex_valid = 1; s.ex_ld = 1; s.ex_rc = 7;
    drive(s, "ld_ex");
    s = '0; s.dec_valid = 1; s.dec_ra = 7; s.mem_valid = 1; s.mem_ld = 1; s.mem_rc = 7;
    drive(s, "ld_mem");
    s = '0; s.dec_valid = 1; s.dec_ra = 7; s.wb_valid = 1; s.wb_rc = 7; s.wb_data = 32'hABCD;
    drive(s, "ld_wb_fwd");

    // 4. long-latency
    s = '0; s.dec_valid = 1; s.ll_issue = 1; s.dec_rc = 9;
    drive(s, "ll_issue9_a");
    drive(s, "ll_issue9_b");
    s = '0; s.dec_valid = 1; s.dec_ra = 9;
    drive(s, "ll_wait");
    s.ll_done = 1; s.ll_rc = 9; s.ll_data = 32'h1;
    drive(s, "ll_done_first");
    s.ll_data = 32'h2;
    drive(s, "ll_done_fwd");
    s = '0; s.dec_valid = 1; s.dec_ra = 9;
    drive(s, "ll_array");

    // 5. saturation and error
    s = '0; s.dec_valid = 1; s.ll_issue = 1; s.dec_rc = 4;
    for (int i = 0; i < 3; i++) drive(s, "sat_issue");
    drive(s, "sat_stall");
    drive(s, "sat_hold");
    s = '0; s.ll_done = 1; s.ll_rc = 6; s.ll_data = 32'h5;
    drive(s, "underflow");
    s = '0;
    drive(s, "err_set");
    drive(s, "err_sticky");

    // 6. conflicts
    s = '0; s.wb_valid = 1; s.wb_rc = 2; s.wb_data = 32'hAA;
    s.ll_done = 1; s.ll_rc = 2; s.ll_data = 32'hBB;
    drive(s, "wb_ll_same");
    s = '0; s.dec_valid = 1; s.dec_ra = 2; s.dec_rb = 2; s.dec_rb_used = 0;
    s.wb_valid = 1; s.wb_rc = 31; s.wb_data = 32'hDEAD;
    drive(s, "r2_ll_wins");
    s = '0; s.dec_valid = 1; s.dec_ra = 31; s.dec_rb = 31; s.dec_rb_used = 0;
    drive(s, "r31_zero");
    s = '0; s.dec_valid = 1; s.ll_issue = 1; s.dec_rc = 9;
    drive(s, "rst_issue9");
    s = '0; s.dec_valid = 1; s.dec_ra = 9;
    drive(s, "rst_pre_stall");
    s.rst = 1;
    drive(s, "rst_mid");
    s.rst = 0;
    drive(s, "rst_cleared");

    // Randomized phase
    for (int n = 0; n < 600; n++) begin
      s             = '0;
      s.rst         = ($urandom_range(0, 63) == 0);
      s.dec_valid   = ($urandom_range(0, 3) != 0);
      s.dec_ra      = rand_addr();
      s.dec_rb      = rand_addr();
      s.dec_rb_used = 1'($urandom_range(0, 1));
      s.dec_rc      = rand_addr();
      s.ll_issue    = ($urandom_range(0, 2) == 0);
      s.ex_valid    = 1'($urandom_range(0, 1));
      s.mem_valid   = 1'($urandom_range(0, 1));
      s.wb_valid    = 1'($urandom_range(0, 1));
      s.ex_ld       = ($urandom_range(0, 3) == 0);
      s.mem_ld      = ($urandom_range(0, 3) == 0);
      s.ex_rc       = rand_addr();
      s.mem_rc      = rand_addr();
      s.wb_rc       = rand_addr();
      s.ll_done     = ($urandom_range(0, 3) == 0);
      s.ll_rc       = rand_addr();
      s.ex_data     = $urandom();
      s.mem_data    = $urandom();
      s.wb_data     = $urandom();
      s.ll_data     = $urandom();
      drive(s, "random");
    end

    // Drain: the monitor must consume every queued prediction.
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
